// File: rtl/prog_loader.sv
// Boot-time program loader: assembles a byte stream into 32-bit words, writes them
// to instruction memory and releases the core from reset once the checksum matches.
module prog_loader #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        load_start,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst_,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] word_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  csum_q, csum_d;
    logic [23:0] word_q, word_d;
    logic [15:0] wc_q, wc_d;
    logic [15:0] to_q, to_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic        we_q, we_d;
    logic        crst_q, crst_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        accept;
    logic        start;
    logic [15:0] n_full;
    logic [31:0] to_inc;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        word_d  = word_q;
        wc_d    = wc_q;
        to_d    = to_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        start   = 1'b0;
        accept  = in_valid & ready_q;
        n_full  = {in_byte, n_q[7:0]};
        to_inc  = {16'd0, to_q} + 32'd1;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: start = load_start;
            S_HDR0: if (accept) begin
                n_d[7:0] = in_byte;
                state_d  = S_HDR1;
            end
            S_HDR1: if (accept) begin
                n_d[15:8] = in_byte;
                if (n_full == 16'd0 || {16'd0, n_full} > DEPTH) state_d = S_ERR;
                else                                             state_d = S_DATA;
            end
            S_DATA: if (accept) begin
                csum_d = csum_q ^ in_byte;
                idx_d  = idx_q + 2'd1;
                unique case (idx_q)
                    2'd0: word_d[7:0]   = in_byte;
                    2'd1: word_d[15:8]  = in_byte;
                    2'd2: word_d[23:16] = in_byte;
                    default: begin
                        // Address uses the pre-increment count; it bumps at the end of WRITE.
                        state_d = S_WRITE;
                        wdata_d = {in_byte, word_q};
                        addr_d  = BASE_ADDR + {14'd0, wc_q, 2'b00};
                    end
                endcase
            end
            S_WRITE: begin
                wc_d    = wc_q + 16'd1;
                to_d    = 16'd0;
                state_d = (wc_d == n_q) ? S_CHK : S_DATA;
            end
            S_CHK: if (accept) begin
                state_d = (in_byte == csum_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase

        // Idle-cycle watchdog, active only while a byte is being awaited.
        if (ready_q) begin
            if (accept) begin
                to_d = 16'd0;
            end else if (TIMEOUT != 0) begin
                to_d = to_inc[15:0];
                if (to_inc == TIMEOUT) state_d = S_ERR;
            end
        end

        if (start) begin
            state_d = S_HDR0;
            wc_d    = 16'd0;
            idx_d   = 2'd0;
            csum_d  = 8'd0;
            to_d    = 16'd0;
        end

        ready_d = state_d inside {S_HDR0, S_HDR1, S_DATA, S_CHK};
        busy_d  = ready_d || (state_d == S_WRITE);
        we_d    = (state_d == S_WRITE);
        crst_d  = (state_d == S_DONE);
        done_d  = (state_d == S_DONE);
        err_d   = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
            word_q  <= '0;
            wc_q    <= '0;
            to_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            crst_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            word_q  <= word_d;
            wc_q    <= wc_d;
            to_q    <= to_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            crst_q  <= crst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign in_ready   = ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_rst_  = crst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good/stalled/bad-checksum loads, header limits,
// idle timeout and asynchronous reset during a memory write.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        load_start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst_;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] word_count;

    prog_loader #(
        .DEPTH(16),
        .BASE_ADDR(32'h0000_0000),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst_(rst_),
        .load_start(load_start),
        .in_valid(in_valid),
        .in_byte(in_byte),
        .in_ready(in_ready),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst_(core_rst_),
        .busy(busy),
        .done(done),
        .err(err),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_acc = 0;
    int t_busy = -1, t_done = -1, t_err = -1;
    int acc_cnt = 0, we_ready_cnt = 0;
    logic busy_p = 1'b0, done_p = 1'b0, err_p = 1'b0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  stim[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observes writes, accepted bytes and status rising edges on the falling edge.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
            if (in_ready) we_ready_cnt++;
        end
        if (in_valid && in_ready) acc_cnt++;
        if (busy && !busy_p) t_busy = cyc;
        if (done && !done_p) t_done = cyc;
        if (err && !err_p)   t_err  = cyc;
        busy_p = busy;
        done_p = done;
        err_p  = err;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic clr_mon();
        wr_addr.delete();
        wr_data.delete();
        acc_cnt      = 0;
        we_ready_cnt = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 load_start = 1'b1;
        @(posedge clk); #1 load_start = 1'b0;
    endtask

    task automatic drive(input bit tog);
        int  i = 0;
        int  k = 0;
        bit  ph = 1'b0;
        bit  acc;
        while (i < stim.size() && k < 200) begin
            in_valid = tog ? ph : 1'b1;
            in_byte  = in_valid ? stim[i] : 8'h5A;
            ph = ~ph;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                i++;
                last_acc = cyc;
            end
            k++;
        end
        in_valid = 1'b0;
        chk("bytes_taken", i, stim.size());
    endtask

    task automatic wait_end(input int budget);
        int k = 0;
        while (!(done || err) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("load_ended", done | err, 1);
        @(negedge clk); #1;
    endtask

    task automatic set_good(input logic [7:0] ck);
        stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, ck};
    endtask

    task automatic check_writes(input string pfx);
        chk({pfx, "_nwr"}, wr_addr.size(), 2);
        if (wr_addr.size() >= 2) begin
            chk({pfx, "_a0"}, wr_addr[0], 32'h0000_0000);
            chk({pfx, "_d0"}, wr_data[0], 32'h0050_0013);
            chk({pfx, "_a1"}, wr_addr[1], 32'h0000_0004);
            chk({pfx, "_d1"}, wr_data[1], 32'h00A0_0093);
        end
    endtask

    // XOR of 13 00 50 00 93 00 A0 00 is 8'h70.
    localparam logic [7:0] GOOD_CK = 8'h70;

    initial begin
        // Reset, then idle with no load_start.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {in_ready, imem_we, core_rst_, busy, done, err, word_count}, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        rst_ = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("idle_outs", {in_ready, imem_we, core_rst_, busy, done, err, word_count}, 0);
        chk("idle_addr", imem_addr, 0);

        // Good load, in_valid held high.
        set_good(GOOD_CK);
        clr_mon();
        pulse_start();
        drive(1'b0);
        wait_end(20);
        check_writes("good");
        chk("good_done", {done, err, core_rst_, busy, in_ready}, 5'b10100);
        chk("good_wc", word_count, 2);
        chk("good_latency", t_done - t_busy, 13);

        // Reload from DONE: core goes back into reset right after the pulse.
        pulse_start();
        chk("reload_state", {core_rst_, done, busy}, 3'b001);
        clr_mon();
        drive(1'b1);
        wait_end(20);
        check_writes("stall");
        chk("stall_done", {done, err, core_rst_}, 3'b101);
        chk("stall_wc", word_count, 2);
        chk("stall_acc", acc_cnt, 11);
        chk("stall_we_ready", we_ready_cnt, 0);

        // Bad checksum, then recovery with a correct stream.
        set_good(8'hFF);
        pulse_start();
        clr_mon();
        drive(1'b0);
        wait_end(20);
        check_writes("badck");
        chk("badck_state", {done, err, core_rst_}, 3'b010);
        chk("badck_wc", word_count, 2);
        set_good(GOOD_CK);
        pulse_start();
        drive(1'b0);
        wait_end(20);
        chk("recover_state", {done, err, core_rst_}, 3'b101);

        // Header N=0.
        stim = '{8'h00, 8'h00};
        pulse_start();
        clr_mon();
        drive(1'b0);
        chk("n0_err", {err, busy, in_ready}, 3'b100);
        repeat (3) @(negedge clk);
        chk("n0_nwr", wr_addr.size(), 0);
        chk("n0_wc", word_count, 0);

        // Header N=DEPTH+1.
        stim = '{8'h11, 8'h00};
        pulse_start();
        clr_mon();
        drive(1'b0);
        chk("n17_err", {err, busy}, 2'b10);
        repeat (3) @(negedge clk);
        chk("n17_nwr", wr_addr.size(), 0);

        // Header N=DEPTH is legal; the stream then stops and the watchdog fires.
        stim = '{8'h10, 8'h00};
        pulse_start();
        drive(1'b0);
        chk("n16_ok", {err, busy, in_ready}, 3'b011);
        repeat (12) @(negedge clk);
        chk("n16_timeout_err", err, 1);

        // Timeout: stop after two data bytes; ERR exactly 8 cycles after the last accept.
        stim = '{8'h02, 8'h00, 8'h13, 8'h00};
        pulse_start();
        clr_mon();
        t_err = -1;
        drive(1'b0);
        for (int k = 0; k < 20 && !err; k++) @(negedge clk);
        @(negedge clk);
        chk("to_err", {err, done, core_rst_, busy}, 4'b1000);
        chk("to_cycles", t_err - last_acc, 8);
        chk("to_nwr", wr_addr.size(), 0);

        // Asynchronous reset while WRITE is active.
        stim = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        pulse_start();
        clr_mon();
        drive(1'b0);
        chk("wr_we", {imem_we, in_ready, busy}, 3'b101);
        chk("wr_addr", imem_addr, 32'h0000_0000);
        chk("wr_data", imem_wdata, 32'h4433_2211);
        #2 rst_ = 1'b0;
        #1;
        chk("arst_outs", {imem_we, core_rst_, busy, in_ready, done, err}, 0);
        chk("arst_wc", word_count, 0);
        chk("arst_wdata", imem_wdata, 0);
        #3 rst_ = 1'b1;
        repeat (2) @(negedge clk);
        chk("arst_nwr", wr_addr.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
